// File: rtl/calc_pkg.sv
// Shared types for the calculator port responder: command/response
// encodings, FSM states and the result-pipeline stage record.
package calc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    OK   = 2'b01,
    OVF  = 2'b10,
    INV  = 2'b11
  } resp_e;

  typedef enum logic {
    IDLE    = 1'b0,
    GET_OP2 = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic core: add/sub with range check, logical shifts,
// and an invalid-command response for anything else.
module calc_alu
  import calc_pkg::*;
(
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output resp_e             resp,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W:0] sum;

  always_comb begin
    resp = INV;
    data = '0;
    sum  = {1'b0, op1} + {1'b0, op2};
    case (cmd)
      ADD: begin
        if (sum[DATA_W]) begin
          resp = OVF;
        end else begin
          resp = OK;
          data = sum[DATA_W-1:0];
        end
      end
      SUB: begin
        if (op1 < op2) begin
          resp = OVF;
        end else begin
          resp = OK;
          data = op1 - op2;
        end
      end
      SHL: begin
        resp = OK;
        data = op1 << op2[4:0];
      end
      SHR: begin
        resp = OK;
        data = op1 >> op2[4:0];
      end
      default: begin
        resp = INV;
        data = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle request port (cmd+op1, then op2) feeding a fixed-latency result
// pipeline, with a saturating count of issued responses.
//
// state   | meaning
// IDLE    | waiting for a nonzero command with operand 1
// GET_OP2 | operand 1 held; next edge samples operand 2 and issues
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int EXEC_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [31:0]       req_data_in,
  output logic [1:0]        out_resp,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              proto_err,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic              issue_q;
  resp_e             alu_resp;
  logic [DATA_W-1:0] alu_data;
  stage_t            pipe [EXEC_LAT];

  calc_alu u_alu (
    .cmd  (cmd_q),
    .op1  (op1_q),
    .op2  (op2_q),
    .resp (alu_resp),
    .data (alu_data)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      issue_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_cmd_in != 4'd0) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            state <= GET_OP2;
          end
        end
        GET_OP2: begin
          // A command arriving here is a protocol slip; its data is still operand 2.
          op2_q   <= req_data_in;
          issue_q <= 1'b1;
          if (req_cmd_in != 4'd0) proto_err <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers add one cycle, so EXEC_LAT stages land the result on edge E+EXEC_LAT.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < EXEC_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: issue_q,
                   resp:  issue_q ? alu_resp : NONE,
                   data:  issue_q ? alu_data : '0};
      for (int i = 1; i < EXEC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      op_count <= '0;
    end else if (pipe[EXEC_LAT-1].valid && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_resp = pipe[EXEC_LAT-1].resp;
  assign out_data = pipe[EXEC_LAT-1].data;
  assign busy     = (state == GET_OP2);

endmodule
